// File: rtl/ccu_ctrl_pkg.sv
// Shared constants and types for the CCU controller snoop-response collector.
package ccu_ctrl_pkg;

    localparam int CR_WAS_UNIQUE    = 4;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_ERROR         = 1;
    localparam int CR_DATA_TRANSFER = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } collector_state_e;

endpackage

// File: rtl/ccu_ctrl_snoop_collector_if.sv
// Snoop-round bundle: round start, per-port CR/CD channels, memory-unit CD push and round summary.
interface ccu_ctrl_snoop_collector_if #(
    parameter int NoMstPorts   = 4,
    parameter int AxiDataWidth = 64
);
    localparam int MstIdxBits = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

    logic                                     start_valid_i;
    logic                                     start_ready_o;
    logic [NoMstPorts-1:0]                    snoop_mask_i;
    logic [NoMstPorts-1:0]                    cr_valid_i;
    logic [NoMstPorts-1:0]                    cr_ready_o;
    logic [NoMstPorts-1:0][4:0]               cr_resp_i;
    logic [NoMstPorts-1:0]                    cd_valid_i;
    logic [NoMstPorts-1:0]                    cd_ready_o;
    logic [NoMstPorts-1:0][AxiDataWidth-1:0]  cd_data_i;
    logic [NoMstPorts-1:0]                    cd_last_i;
    logic [AxiDataWidth-1:0]                  cd_o;
    logic                                     cd_handshake_o;
    logic                                     cd_fifo_full_i;
    logic                                     sum_valid_o;
    logic                                     sum_data_o;
    logic                                     sum_dirty_o;
    logic                                     sum_shared_o;
    logic                                     sum_error_o;
    logic [MstIdxBits-1:0]                    first_responder_o;

    modport master (
        output start_valid_i, snoop_mask_i, cr_valid_i, cr_resp_i,
               cd_valid_i, cd_data_i, cd_last_i, cd_fifo_full_i,
        input  start_ready_o, cr_ready_o, cd_ready_o, cd_o, cd_handshake_o,
               sum_valid_o, sum_data_o, sum_dirty_o, sum_shared_o, sum_error_o,
               first_responder_o
    );

    modport slave (
        input  start_valid_i, snoop_mask_i, cr_valid_i, cr_resp_i,
               cd_valid_i, cd_data_i, cd_last_i, cd_fifo_full_i,
        output start_ready_o, cr_ready_o, cd_ready_o, cd_o, cd_handshake_o,
               sum_valid_o, sum_data_o, sum_dirty_o, sum_shared_o, sum_error_o,
               first_responder_o
    );

endinterface

// File: rtl/ccu_ctrl_lzc_first.sv
// Lowest-index picker: returns the index of the lowest set request bit.
module ccu_ctrl_lzc_first #(
    parameter int NumIn = 4,
    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0] req,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (req[i]) idx = IdxW'(i);
        end
    end

endmodule

// File: rtl/ccu_ctrl_snoop_collector.sv
// Collects CR responses of one snoop round into a summary and forwards the first
// data responder's cache line into the memory-unit CD FIFO, draining all other CD.
module ccu_ctrl_snoop_collector
    import ccu_ctrl_pkg::*;
#(
    parameter int NoMstPorts      = 4,
    parameter int AxiDataWidth    = 64,
    parameter int DcacheLineWidth = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ccu_ctrl_snoop_collector_if.slave bus
);

    localparam int DcacheLineWords = DcacheLineWidth / AxiDataWidth;
    localparam int MstIdxBits      = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
    localparam int BeatW           = (DcacheLineWords > 1) ? $clog2(DcacheLineWords) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(DcacheLineWords - 1);

    collector_state_e state_q, state_d;

    logic [NoMstPorts-1:0]            cr_pending_q, cr_pending_d;
    logic [NoMstPorts-1:0]            cd_pending_q, cd_pending_d;
    logic [NoMstPorts-1:0][BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic data_q, data_d, dirty_q, dirty_d, shared_q, shared_d, error_q, error_d;
    logic [MstIdxBits-1:0]            first_q, first_d;

    logic [NoMstPorts-1:0] cr_ready, cd_ready, cr_acc, cd_acc, dt_vec;
    logic [NoMstPorts-1:0] was_unique_unused;
    logic [MstIdxBits-1:0] lzc_idx;
    logic                  lzc_found;
    logic                  collect;

    assign collect = (state_q == ST_COLLECT);

    ccu_ctrl_lzc_first #(.NumIn(NoMstPorts)) u_first (
        .req   (dt_vec),
        .idx   (lzc_idx),
        .found (lzc_found)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Exit on next-state masks so the cycle of the final handshake already moves on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start_valid_i) state_d = (bus.snoop_mask_i == '0) ? ST_DONE : ST_COLLECT;
            ST_COLLECT: if (cr_pending_d == '0 && cd_pending_d == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready_o = (state_q == ST_IDLE);
        cr_ready          = collect ? cr_pending_q : '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            // Only the forwarded port feels back-pressure from the memory-unit FIFO.
            cd_ready[i] = collect & cd_pending_q[i]
                        & ~(data_q & (first_q == MstIdxBits'(i)) & bus.cd_fifo_full_i);
        end
        bus.cr_ready_o        = cr_ready;
        bus.cd_ready_o        = cd_ready;
        bus.cd_handshake_o    = collect & data_q & bus.cd_valid_i[first_q] & cd_ready[first_q];
        bus.cd_o              = (collect & data_q) ? bus.cd_data_i[first_q] : '0;
        bus.sum_valid_o       = (state_q == ST_DONE);
        bus.sum_data_o        = bus.sum_valid_o & data_q;
        bus.sum_dirty_o       = bus.sum_valid_o & dirty_q;
        bus.sum_shared_o      = bus.sum_valid_o & shared_q;
        bus.sum_error_o       = bus.sum_valid_o & error_q;
        bus.first_responder_o = bus.sum_valid_o ? first_q : '0;
    end

    always_comb begin
        cr_acc = bus.cr_valid_i & cr_ready;
        cd_acc = bus.cd_valid_i & cd_ready;
        for (int i = 0; i < NoMstPorts; i++) begin
            dt_vec[i]            = cr_acc[i] & bus.cr_resp_i[i][CR_DATA_TRANSFER];
            was_unique_unused[i] = bus.cr_resp_i[i][CR_WAS_UNIQUE];
        end
    end

    always_comb begin
        cr_pending_d = cr_pending_q;
        cd_pending_d = cd_pending_q;
        beat_cnt_d   = beat_cnt_q;
        data_d       = data_q;
        dirty_d      = dirty_q;
        shared_d     = shared_q;
        error_d      = error_q;
        first_d      = first_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid_i) cr_pending_d = bus.snoop_mask_i;
            end
            ST_COLLECT: begin
                cr_pending_d = cr_pending_q & ~cr_acc;
                cd_pending_d = cd_pending_q | dt_vec;
                if (!data_q && lzc_found) begin
                    data_d  = 1'b1;
                    first_d = lzc_idx;
                end
                for (int i = 0; i < NoMstPorts; i++) begin
                    if (cr_acc[i]) begin
                        shared_d = shared_d | bus.cr_resp_i[i][CR_IS_SHARED];
                        error_d  = error_d | bus.cr_resp_i[i][CR_ERROR];
                    end
                    if (dt_vec[i]) dirty_d = dirty_d | bus.cr_resp_i[i][CR_PASS_DIRTY];
                    // The beat counter, not cd_last, decides where the line ends.
                    if (cd_acc[i]) begin
                        if (bus.cd_last_i[i] != (beat_cnt_q[i] == LastBeat)) error_d = 1'b1;
                        if (beat_cnt_q[i] == LastBeat) begin
                            beat_cnt_d[i]   = '0;
                            cd_pending_d[i] = 1'b0;
                        end else begin
                            beat_cnt_d[i] = beat_cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: begin
                cr_pending_d = '0;
                cd_pending_d = '0;
                beat_cnt_d   = '0;
                data_d       = 1'b0;
                dirty_d      = 1'b0;
                shared_d     = 1'b0;
                error_d      = 1'b0;
                first_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cr_pending_q <= '0;
            cd_pending_q <= '0;
            beat_cnt_q   <= '0;
            data_q       <= 1'b0;
            dirty_q      <= 1'b0;
            shared_q     <= 1'b0;
            error_q      <= 1'b0;
            first_q      <= '0;
        end else begin
            cr_pending_q <= cr_pending_d;
            cd_pending_q <= cd_pending_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            dirty_q      <= dirty_d;
            shared_q     <= shared_d;
            error_q      <= error_d;
            first_q      <= first_d;
        end
    end

endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Randomized bench for the snoop collector against a round-level reference model.
module tb_ccu_ctrl_snoop_collector;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int LW = 128;
    localparam int W  = LW / DW;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccu_ctrl_snoop_collector_if #(.NoMstPorts(N), .AxiDataWidth(DW)) bus ();

    ccu_ctrl_snoop_collector #(
        .NoMstPorts(N), .AxiDataWidth(DW), .DcacheLineWidth(LW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] r_mask, r_dt, r_pd, r_sh, r_er, r_lb;
    int           r_del [N];
    int           r_fs, r_fl, r_rb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start_valid_i  = 1'b0;
        bus.snoop_mask_i   = '0;
        bus.cr_valid_i     = '0;
        bus.cr_resp_i      = '0;
        bus.cd_valid_i     = '0;
        bus.cd_data_i      = '0;
        bus.cd_last_i      = '0;
        bus.cd_fifo_full_i = 1'b0;
    endtask

    task automatic set_round(input logic [N-1:0] m, dt, pd, sh, er, lb,
                             input int d, fs, fl, rb);
        r_mask = m; r_dt = dt & m; r_pd = pd; r_sh = sh; r_er = er; r_lb = lb & dt & m;
        for (int i = 0; i < N; i++) r_del[i] = d;
        r_fs = fs; r_fl = fl; r_rb = rb;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_start_ready"}, bus.start_ready_o, 1);
        chk({nm, "_cr_ready"},    bus.cr_ready_o, 0);
        chk({nm, "_cd_ready"},    bus.cd_ready_o, 0);
        chk({nm, "_handshake"},   bus.cd_handshake_o, 0);
        chk({nm, "_sum_valid"},   bus.sum_valid_o, 0);
    endtask

    task automatic run_round(input string nm);
        logic [DW-1:0] beat_d [N][W];
        logic [DW-1:0] got[$];
        logic [DW-1:0] exp_q[$];
        int  beats [N];
        bit  cr_done [N];
        bit  cd_act [N];
        bit  cd_hold [N];
        int  first = 0, first_del = 1000, maxdel = 0, sum_c = -1;
        bit  e_data = 0, e_dirty = 0, e_shared = 0, e_error = 0, aborted = 0;
        logic s_data = 0, s_dirty = 0, s_shared = 0, s_error = 0;
        logic [IW-1:0] s_first = '0;

        // Reference expectations straight from the round rules.
        for (int i = 0; i < N; i++) begin
            beats[i] = 0; cr_done[i] = 0; cd_act[i] = 0; cd_hold[i] = 0;
            for (int b = 0; b < W; b++) beat_d[i][b] = {$urandom, $urandom};
            if (r_mask[i]) begin
                if (r_del[i] > maxdel) maxdel = r_del[i];
                e_shared |= r_sh[i];
                e_error  |= r_er[i];
                if (r_dt[i]) begin
                    e_data   = 1;
                    e_dirty |= r_pd[i];
                    e_error |= r_lb[i];
                    if (r_del[i] < first_del) begin first_del = r_del[i]; first = i; end
                end
            end
        end
        if (e_data) for (int b = 0; b < W; b++) exp_q.push_back(beat_d[first][b]);

        @(negedge clk);
        bus.start_valid_i = 1'b1;
        bus.snoop_mask_i  = r_mask;
        #1;
        chk({nm, "_start_ready"}, bus.start_ready_o, 1);

        for (int c = 1; c <= 300 && sum_c < 0 && !aborted; c++) begin
            @(negedge clk);
            bus.start_valid_i  = 1'b0;
            bus.snoop_mask_i   = '0;
            bus.cd_fifo_full_i = (c >= r_fs && c < r_fs + r_fl);
            for (int i = 0; i < N; i++) begin
                bus.cr_valid_i[i] = r_mask[i] && !cr_done[i] && c > r_del[i];
                bus.cr_resp_i[i]  = {1'($urandom), r_sh[i], r_pd[i], r_er[i], r_dt[i]};
                if (cd_act[i]) begin
                    if (!cd_hold[i]) cd_hold[i] = ($urandom % 4) != 0;
                    bus.cd_valid_i[i] = cd_hold[i];
                    bus.cd_data_i[i]  = beat_d[i][beats[i]];
                    bus.cd_last_i[i]  = (beats[i] == W - 1) ^ (r_lb[i] && beats[i] == 0);
                end else begin
                    bus.cd_valid_i[i] = 1'($urandom);
                    bus.cd_data_i[i]  = {$urandom, $urandom};
                    bus.cd_last_i[i]  = 1'($urandom);
                end
            end
            #1;
            if (bus.cd_handshake_o) got.push_back(bus.cd_o);
            for (int i = 0; i < N; i++) begin
                if (cd_act[i] && cd_hold[i]) begin
                    chk({nm, "_cd_ready"}, bus.cd_ready_o[i], !(i == first && bus.cd_fifo_full_i));
                    if (bus.cd_ready_o[i]) begin
                        cd_hold[i] = 0;
                        beats[i]++;
                        if (beats[i] == W) cd_act[i] = 0;
                    end
                end else if (bus.cd_valid_i[i]) begin
                    chk({nm, "_cd_ready_off"}, bus.cd_ready_o[i], 0);
                end
                if (bus.cr_valid_i[i]) begin
                    chk({nm, "_cr_ready"}, bus.cr_ready_o[i], 1);
                    if (bus.cr_ready_o[i]) begin
                        cr_done[i] = 1;
                        if (r_dt[i]) cd_act[i] = 1;
                    end
                end
            end
            if (bus.sum_valid_o) begin
                sum_c    = c;
                s_data   = bus.sum_data_o;
                s_dirty  = bus.sum_dirty_o;
                s_shared = bus.sum_shared_o;
                s_error  = bus.sum_error_o;
                s_first  = bus.first_responder_o;
            end
            if (r_rb >= 0 && got.size() == r_rb && sum_c < 0) begin
                @(negedge clk);
                rst = 1'b1;
                idle_inputs();
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_quiet({nm, "_after_rst"});
                repeat (3) begin
                    @(negedge clk); #1;
                    chk({nm, "_no_sum_after_rst"}, bus.sum_valid_o, 0);
                end
                aborted = 1;
            end
        end
        idle_inputs();
        if (aborted) return;

        if (sum_c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: sum_valid_o never seen, required within 300 cycles", nm);
            return;
        end
        chk({nm, "_data"},   s_data,   e_data);
        chk({nm, "_dirty"},  s_dirty,  e_dirty);
        chk({nm, "_shared"}, s_shared, e_shared);
        chk({nm, "_error"},  s_error,  e_error);
        chk({nm, "_first"},  s_first,  e_data ? first : 0);
        chk({nm, "_beats"},  got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            chk({nm, "_beat_val"}, got[k], exp_q[k]);
        if (!e_data) chk({nm, "_latency"}, sum_c, (r_mask == '0) ? 1 : maxdel + 2);
        @(negedge clk); #1;
        chk({nm, "_pulse"}, bus.sum_valid_o, 0);
        chk({nm, "_idle_again"}, bus.start_ready_o, 1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;

        set_round(4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);
        run_round("fwd_dirty");
        set_round(4'b1011, 4'b1001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, -1);
        run_round("tie_drain");
        set_round(4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2, 5, -1);
        run_round("fifo_full");
        set_round(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);
        run_round("empty_mask");
        set_round(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, -1);
        run_round("last_err");
        set_round(4'b1101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 0, 0, 0, -1);
        r_del[0] = 3; r_del[2] = 1;
        run_round("no_data");
        set_round(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 1);
        run_round("mid_rst");
        set_round(4'b0110, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);
        run_round("post_rst");

        for (int t = 0; t < 40; t++) begin
            set_round(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000,
                      (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000,
                      0, 1 + ($urandom % 8), $urandom % 7, -1);
            for (int i = 0; i < N; i++) r_del[i] = $urandom % 5;
            run_round("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
